wave_instr_feeder: RTL and testbench
====================================

WAVE_INSTR_FEEDER -- requirements
Module: wave_instr_feeder

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of fetch-entry slots; must be a power of 2.
- REQ-002 SHALL have ports `clk`, input, 1 bit: the single clock. `rst`, input, 1 bit: reset, synchronous and active-high.
- REQ-003 SHALL have fetch-side ports, all inputs except one:
  - `fetch_valid`, input, 1 bit: a fetch entry is offered.
  - `fetch_ready`, output, 1 bit: an entry can be accepted.
  - `fetch_wfid`, input, 6 bits: wavefront ID.
  - `fetch_pc`, input, 32 bits: PC.
  - `fetch_instr_lo`, input, 32 bits: low dword.
  - `fetch_instr_hi`, input, 32 bits: high dword.
  - `fetch_hi_valid`, input, 1 bit: the high dword is valid.
  - `fetch_vgpr_base`, input, 10 bits; `fetch_sgpr_base`, input, 9 bits; `fetch_lds_base`, input, 16 bits: register and LDS bases.
- REQ-004 SHALL have decode-side outputs: `wave_instr_valid` (1 bit), `wave_instr` (32 bits), `wave_instr_pc` (32 bits), `wave_wfid` (6 bits), `wave_vgpr_base` (10 bits), `wave_sgpr_base` (9 bits), `wave_lds_base` (16 bits). All are registered.
- REQ-005 SHALL have inputs `wave_ins_half_rqd` (1 bit): decode requests the second dword. `wave_ins_half_wfid` (6 bits): the requesting wavefront.
- REQ-006 SHALL have a miss port:
  - `hi_fetch_req`, output, 1 bit.
  - `hi_fetch_wfid`, output, 6 bits.
  - `hi_fetch_pc`, output, 32 bits.
  - `hi_fetch_ack`, input, 1 bit.
  - `hi_fetch_instr`, input, 32 bits.
- REQ-007 SHALL have PC-advance outputs: `pc_adv_valid` (1 bit), `pc_adv_wfid` (6 bits), and `pc_adv_bytes` (4 bits, value 4 or 8), reporting how many bytes were consumed.

Function
- REQ-008 SHALL push an entry into the FIFO when fetch_valid and fetch_ready are both 1; fetch_ready = FIFO not full.
- REQ-009 SHALL allow a push and a pop in the same cycle; when the FIFO is full, fetch_ready is 0 even if a pop occurs that cycle.
- REQ-010 SHALL implement the states IDLE, LO, CHECK, HI and MISS. wave_instr_valid=1 only in LO and HI.
- REQ-011 IDLE: when the FIFO is non-empty, pop the head into the current-entry register and go to LO; otherwise stay in IDLE.
- REQ-012 LO: drive the current entry's lo dword, pc, wfid and bases on the decode outputs; go to CHECK next cycle.
- REQ-013 CHECK: drive valid=0 and sample wave_ins_half_rqd.
  - If it is 1 and wave_ins_half_wfid equals the current wfid: go to HI when hi_valid=1, else to MISS.
  - Otherwise: pulse pc_adv with bytes=4 and go to IDLE.
- REQ-014 SHALL ignore wave_ins_half_rqd in every state except CHECK, and also in CHECK when the wfid mismatches.
- REQ-015 MISS: hold hi_fetch_req=1, with the current wfid and pc+4, until hi_fetch_ack. On ack, capture hi_fetch_instr and go to HI.
- REQ-016 HI: drive the hi dword with wave_instr_pc = pc+4, using modulo-2^32 wrap. Pulse pc_adv with bytes=8 and go to IDLE.
- REQ-017 pc_adv_valid SHALL be a single-cycle pulse, asserted exactly once per popped entry.
- REQ-018 Latency SHALL be: push to LO is at least 2 cycles; LO to HI is 2 cycles when no miss occurs.

Reset
- REQ-019 On rst, the block SHALL:
  - set state to IDLE;
  - empty the FIFO;
  - drive wave_instr_valid=0, hi_fetch_req=0 and pc_adv_valid=0;
  - set all data outputs to 0.
- REQ-020 A reset in MISS or HI SHALL drop the outstanding entry without a pc_adv pulse, and deassert hi_fetch_req in the cycle after rst.

Configuration
- REQ-021 SHALL support the macro WAVE_INSTR_FEEDER_LOOKAHEAD_EN.
  - Defined: in CHECK without a matching request, and in HI, when the FIFO is non-empty, pop the head and go straight to LO, skipping IDLE.
  - Undefined: these exits always pass through IDLE.

Structure
- REQ-022 The shared package SHALL hold the state encoding, the FIFO entry width (the sum of all fetch_* fields) and the PC increment constants 4 and 8.
- REQ-023 The FIFO SHALL be a sub-module named feeder_fifo, parameterized by depth and width.

Verification
- REQ-024 SHALL cover a single short entry: push wfid=3, pc=0x100 with no half request → one LO beat with pc 0x100, then pc_adv bytes=4 for wfid=3.
- REQ-025 SHALL cover a long entry with hi_valid=1: push wfid=5, pc=0x200, lo=0xAAAA0000, hi=0x12345678; assert half_rqd with wfid 5 in CHECK → HI beat with instr 0x12345678 and pc 0x204, then pc_adv bytes=8.
- REQ-026 SHALL cover a miss: same entry with hi_valid=0 → hi_fetch_req with pc 0x204, ack delayed 3 cycles with instr 0xDEADBEEF → HI beat carries 0xDEADBEEF.
- REQ-027 SHALL cover a wfid mismatch: half_rqd=1 with wfid 7 while the current wfid is 5 → no HI beat; pc_adv bytes=4.
- REQ-028 SHALL cover backpressure: push 5 entries back to back → fetch_ready=0 after 4; entries drain in order 0,1,2,3,4.
- REQ-029 SHALL cover PC wrap: entry with pc=0xFFFFFFFC and a matching half_rqd → the HI beat has wave_instr_pc = 0x00000000.

Source files
------------

// File: rtl/wave_instr_feeder_pkg.sv
// Shared types and constants for the wavefront instruction feeder and its entry FIFO.
package wave_instr_feeder_pkg;

  localparam int unsigned WFID_W  = 6;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned VGPR_W  = 10;
  localparam int unsigned SGPR_W  = 9;
  localparam int unsigned LDS_W   = 16;
  localparam int unsigned BYTES_W = 4;

  localparam int unsigned ENTRY_W =
    WFID_W + PC_W + INSTR_W + INSTR_W + 1 + VGPR_W + SGPR_W + LDS_W;

  localparam logic [BYTES_W-1:0] PC_INC_LO = 4'd4;
  localparam logic [BYTES_W-1:0] PC_INC_HI = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_CHECK = 3'd2,
    ST_HI    = 3'd3,
    ST_MISS  = 3'd4
  } feeder_state_e;

  typedef struct packed {
    logic [WFID_W-1:0]  wfid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr_lo;
    logic [INSTR_W-1:0] instr_hi;
    logic               hi_valid;
    logic [VGPR_W-1:0]  vgpr_base;
    logic [SGPR_W-1:0]  sgpr_base;
    logic [LDS_W-1:0]   lds_base;
  } fetch_entry_t;

endpackage

// File: rtl/wave_instr_feeder_fifo.sv
// feeder_fifo: synchronous FIFO of fetch entries; push is refused whenever full,
// even if a pop happens in the same cycle.
module feeder_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign head_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wave_instr_feeder.sv
// Buffers fetched instruction entries and feeds decode one dword (or two) per entry.
// WAVE_INSTR_FEEDER_LOOKAHEAD_EN: pop the next entry directly from CHECK/HI, skipping IDLE.
module wave_instr_feeder
  import wave_instr_feeder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [WFID_W-1:0]   fetch_wfid,
  input  logic [PC_W-1:0]     fetch_pc,
  input  logic [INSTR_W-1:0]  fetch_instr_lo,
  input  logic [INSTR_W-1:0]  fetch_instr_hi,
  input  logic                fetch_hi_valid,
  input  logic [VGPR_W-1:0]   fetch_vgpr_base,
  input  logic [SGPR_W-1:0]   fetch_sgpr_base,
  input  logic [LDS_W-1:0]    fetch_lds_base,
  output logic                wave_instr_valid,
  output logic [INSTR_W-1:0]  wave_instr,
  output logic [PC_W-1:0]     wave_instr_pc,
  output logic [WFID_W-1:0]   wave_wfid,
  output logic [VGPR_W-1:0]   wave_vgpr_base,
  output logic [SGPR_W-1:0]   wave_sgpr_base,
  output logic [LDS_W-1:0]    wave_lds_base,
  input  logic                wave_ins_half_rqd,
  input  logic [WFID_W-1:0]   wave_ins_half_wfid,
  output logic                hi_fetch_req,
  output logic [WFID_W-1:0]   hi_fetch_wfid,
  output logic [PC_W-1:0]     hi_fetch_pc,
  input  logic                hi_fetch_ack,
  input  logic [INSTR_W-1:0]  hi_fetch_instr,
  output logic                pc_adv_valid,
  output logic [WFID_W-1:0]   pc_adv_wfid,
  output logic [BYTES_W-1:0]  pc_adv_bytes
);

  feeder_state_e state_q, state_d;
  fetch_entry_t  cur_q, cur_d;
  fetch_entry_t  push_entry, head_entry;
  logic          fifo_full, fifo_empty, pop_c, half_match_c;

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [WFID_W-1:0]  wfid_q, wfid_d;
  logic [VGPR_W-1:0]  vgpr_q, vgpr_d;
  logic [SGPR_W-1:0]  sgpr_q, sgpr_d;
  logic [LDS_W-1:0]   lds_q, lds_d;
  logic               hreq_q, hreq_d;
  logic [WFID_W-1:0]  hwfid_q, hwfid_d;
  logic [PC_W-1:0]    hpc_q, hpc_d;
  logic               adv_q, adv_d;
  logic [WFID_W-1:0]  adv_wfid_q, adv_wfid_d;
  logic [BYTES_W-1:0] adv_bytes_q, adv_bytes_d;

  assign push_entry = '{wfid: fetch_wfid, pc: fetch_pc, instr_lo: fetch_instr_lo,
                        instr_hi: fetch_instr_hi, hi_valid: fetch_hi_valid,
                        vgpr_base: fetch_vgpr_base, sgpr_base: fetch_sgpr_base,
                        lds_base: fetch_lds_base};
  assign fetch_ready = !fifo_full;

  feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch_valid),
    .push_data_i (push_entry),
    .pop_i       (pop_c),
    .head_data_o (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign half_match_c = wave_ins_half_rqd && (wave_ins_half_wfid == cur_q.wfid);

  // Next state, then outputs derived from the next state so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pop_c       = 1'b0;
    valid_d     = 1'b0;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    wfid_d      = wfid_q;
    vgpr_d      = vgpr_q;
    sgpr_d      = sgpr_q;
    lds_d       = lds_q;
    hreq_d      = 1'b0;
    hwfid_d     = hwfid_q;
    hpc_d       = hpc_q;
    adv_d       = 1'b0;
    adv_wfid_d  = adv_wfid_q;
    adv_bytes_d = adv_bytes_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          cur_d   = head_entry;
          state_d = ST_LO;
        end
      end
      ST_LO: state_d = ST_CHECK;
      ST_CHECK: begin
        if (half_match_c) begin
          state_d = cur_q.hi_valid ? ST_HI : ST_MISS;
        end else begin
          adv_d       = 1'b1;
          adv_wfid_d  = cur_q.wfid;
          adv_bytes_d = PC_INC_LO;
          state_d     = ST_IDLE;
`ifdef WAVE_INSTR_FEEDER_LOOKAHEAD_EN
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            cur_d   = head_entry;
            state_d = ST_LO;
          end
`endif
        end
      end
      ST_MISS: begin
        if (hi_fetch_ack) begin
          cur_d.instr_hi = hi_fetch_instr;
          cur_d.hi_valid = 1'b1;
          state_d        = ST_HI;
        end
      end
      ST_HI: begin
        adv_d       = 1'b1;
        adv_wfid_d  = cur_q.wfid;
        adv_bytes_d = PC_INC_HI;
        state_d     = ST_IDLE;
`ifdef WAVE_INSTR_FEEDER_LOOKAHEAD_EN
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          cur_d   = head_entry;
          state_d = ST_LO;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_LO, ST_HI: begin
        valid_d = 1'b1;
        wfid_d  = cur_d.wfid;
        vgpr_d  = cur_d.vgpr_base;
        sgpr_d  = cur_d.sgpr_base;
        lds_d   = cur_d.lds_base;
        if (state_d == ST_LO) begin
          instr_d = cur_d.instr_lo;
          ipc_d   = cur_d.pc;
        end else begin
          instr_d = cur_d.instr_hi;
          ipc_d   = cur_d.pc + PC_W'(PC_INC_LO);
        end
      end
      ST_MISS: begin
        hreq_d  = 1'b1;
        hwfid_d = cur_d.wfid;
        hpc_d   = cur_d.pc + PC_W'(PC_INC_LO);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      ipc_q       <= '0;
      wfid_q      <= '0;
      vgpr_q      <= '0;
      sgpr_q      <= '0;
      lds_q       <= '0;
      hreq_q      <= 1'b0;
      hwfid_q     <= '0;
      hpc_q       <= '0;
      adv_q       <= 1'b0;
      adv_wfid_q  <= '0;
      adv_bytes_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      wfid_q      <= wfid_d;
      vgpr_q      <= vgpr_d;
      sgpr_q      <= sgpr_d;
      lds_q       <= lds_d;
      hreq_q      <= hreq_d;
      hwfid_q     <= hwfid_d;
      hpc_q       <= hpc_d;
      adv_q       <= adv_d;
      adv_wfid_q  <= adv_wfid_d;
      adv_bytes_q <= adv_bytes_d;
    end
  end

  assign wave_instr_valid = valid_q;
  assign wave_instr       = instr_q;
  assign wave_instr_pc    = ipc_q;
  assign wave_wfid        = wfid_q;
  assign wave_vgpr_base   = vgpr_q;
  assign wave_sgpr_base   = sgpr_q;
  assign wave_lds_base    = lds_q;
  assign hi_fetch_req     = hreq_q;
  assign hi_fetch_wfid    = hwfid_q;
  assign hi_fetch_pc      = hpc_q;
  assign pc_adv_valid     = adv_q;
  assign pc_adv_wfid      = adv_wfid_q;
  assign pc_adv_bytes     = adv_bytes_q;

endmodule

// File: tb/tb_wave_instr_feeder.sv
// Directed bench for wave_instr_feeder: short, long, miss, mismatch, wrap, backpressure, reset.
module tb_wave_instr_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [5:0]  fetch_wfid = '0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr_lo = '0;
  logic [31:0] fetch_instr_hi = '0;
  logic        fetch_hi_valid = 1'b0;
  logic [9:0]  fetch_vgpr_base = '0;
  logic [8:0]  fetch_sgpr_base = '0;
  logic [15:0] fetch_lds_base = '0;
  logic        wave_instr_valid;
  logic [31:0] wave_instr;
  logic [31:0] wave_instr_pc;
  logic [5:0]  wave_wfid;
  logic [9:0]  wave_vgpr_base;
  logic [8:0]  wave_sgpr_base;
  logic [15:0] wave_lds_base;
  logic        wave_ins_half_rqd = 1'b0;
  logic [5:0]  wave_ins_half_wfid = '0;
  logic        hi_fetch_req;
  logic [5:0]  hi_fetch_wfid;
  logic [31:0] hi_fetch_pc;
  logic        hi_fetch_ack = 1'b0;
  logic [31:0] hi_fetch_instr = '0;
  logic        pc_adv_valid;
  logic [5:0]  pc_adv_wfid;
  logic [3:0]  pc_adv_bytes;

  int n_checks = 0;
  int n_errors = 0;

  wave_instr_feeder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wfid(fetch_wfid),
    .fetch_pc(fetch_pc), .fetch_instr_lo(fetch_instr_lo), .fetch_instr_hi(fetch_instr_hi),
    .fetch_hi_valid(fetch_hi_valid), .fetch_vgpr_base(fetch_vgpr_base),
    .fetch_sgpr_base(fetch_sgpr_base), .fetch_lds_base(fetch_lds_base),
    .wave_instr_valid(wave_instr_valid), .wave_instr(wave_instr), .wave_instr_pc(wave_instr_pc),
    .wave_wfid(wave_wfid), .wave_vgpr_base(wave_vgpr_base), .wave_sgpr_base(wave_sgpr_base),
    .wave_lds_base(wave_lds_base), .wave_ins_half_rqd(wave_ins_half_rqd),
    .wave_ins_half_wfid(wave_ins_half_wfid), .hi_fetch_req(hi_fetch_req),
    .hi_fetch_wfid(hi_fetch_wfid), .hi_fetch_pc(hi_fetch_pc), .hi_fetch_ack(hi_fetch_ack),
    .hi_fetch_instr(hi_fetch_instr), .pc_adv_valid(pc_adv_valid), .pc_adv_wfid(pc_adv_wfid),
    .pc_adv_bytes(pc_adv_bytes)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_entry(input logic [5:0] wfid, input logic [31:0] pc,
                             input logic [31:0] lo, input logic [31:0] hi, input logic hv);
    fetch_wfid      = wfid;
    fetch_pc        = pc;
    fetch_instr_lo  = lo;
    fetch_instr_hi  = hi;
    fetch_hi_valid  = hv;
    fetch_vgpr_base = 10'(wfid) * 10'd4;
    fetch_sgpr_base = 9'(wfid) * 9'd2;
    fetch_lds_base  = 16'(wfid) * 16'h0100;
  endtask

  task automatic push_entry(input logic [5:0] wfid, input logic [31:0] pc,
                            input logic [31:0] lo, input logic [31:0] hi, input logic hv);
    drive_entry(wfid, pc, lo, hi, hv);
    fetch_valid = 1'b1;
    tick;
    fetch_valid = 1'b0;
  endtask

  initial begin : stim
    int idx;
    logic pend;
    logic rdy_before;

    tick;
    tick;
    rst = 1'b0;
    check("rst_valid", 64'(wave_instr_valid), 64'd0);
    check("rst_hreq", 64'(hi_fetch_req), 64'd0);
    check("rst_adv", 64'(pc_adv_valid), 64'd0);
    check("rst_instr", 64'(wave_instr), 64'd0);
    check("rst_pc", 64'(wave_instr_pc), 64'd0);
    check("rst_ready", 64'(fetch_ready), 64'd1);

    // Short entry: one LO beat, then a 4-byte advance.
    push_entry(6'd3, 32'h100, 32'h1111_0000, 32'h0, 1'b0);
    tick;
    check("s_lo_valid", 64'(wave_instr_valid), 64'd1);
    check("s_lo_instr", 64'(wave_instr), 64'h1111_0000);
    check("s_lo_pc", 64'(wave_instr_pc), 64'h100);
    check("s_lo_wfid", 64'(wave_wfid), 64'd3);
    check("s_lo_vgpr", 64'(wave_vgpr_base), 64'd12);
    check("s_lo_sgpr", 64'(wave_sgpr_base), 64'd6);
    check("s_lo_lds", 64'(wave_lds_base), 64'h300);
    tick;
    check("s_chk_valid", 64'(wave_instr_valid), 64'd0);
    check("s_chk_adv", 64'(pc_adv_valid), 64'd0);
    tick;
    check("s_adv", 64'(pc_adv_valid), 64'd1);
    check("s_adv_wfid", 64'(pc_adv_wfid), 64'd3);
    check("s_adv_bytes", 64'(pc_adv_bytes), 64'd4);
    check("s_no_hi", 64'(wave_instr_valid), 64'd0);
    tick;
    check("s_adv_pulse", 64'(pc_adv_valid), 64'd0);

    // Long entry with hi dword present.
    push_entry(6'd5, 32'h200, 32'hAAAA_0000, 32'h1234_5678, 1'b1);
    tick;
    check("l_lo_instr", 64'(wave_instr), 64'hAAAA_0000);
    tick;
    wave_ins_half_rqd  = 1'b1;
    wave_ins_half_wfid = 6'd5;
    tick;
    wave_ins_half_rqd = 1'b0;
    check("l_hi_valid", 64'(wave_instr_valid), 64'd1);
    check("l_hi_instr", 64'(wave_instr), 64'h1234_5678);
    check("l_hi_pc", 64'(wave_instr_pc), 64'h204);
    check("l_hi_wfid", 64'(wave_wfid), 64'd5);
    check("l_hi_noadv", 64'(pc_adv_valid), 64'd0);
    tick;
    check("l_adv", 64'(pc_adv_valid), 64'd1);
    check("l_adv_bytes", 64'(pc_adv_bytes), 64'd8);
    check("l_adv_wfid", 64'(pc_adv_wfid), 64'd5);
    check("l_end_valid", 64'(wave_instr_valid), 64'd0);

    // Miss: hi dword fetched through the miss port, ack after 3 cycles.
    push_entry(6'd5, 32'h200, 32'hAAAA_0000, 32'h0, 1'b0);
    tick;
    tick;
    wave_ins_half_rqd  = 1'b1;
    wave_ins_half_wfid = 6'd5;
    tick;
    wave_ins_half_rqd = 1'b0;
    check("m_req", 64'(hi_fetch_req), 64'd1);
    check("m_req_pc", 64'(hi_fetch_pc), 64'h204);
    check("m_req_wfid", 64'(hi_fetch_wfid), 64'd5);
    check("m_valid", 64'(wave_instr_valid), 64'd0);
    tick;
    check("m_hold1", 64'(hi_fetch_req), 64'd1);
    tick;
    check("m_hold2", 64'(hi_fetch_req), 64'd1);
    hi_fetch_ack   = 1'b1;
    hi_fetch_instr = 32'hDEAD_BEEF;
    tick;
    hi_fetch_ack = 1'b0;
    check("m_hi_valid", 64'(wave_instr_valid), 64'd1);
    check("m_hi_instr", 64'(wave_instr), 64'hDEAD_BEEF);
    check("m_hi_pc", 64'(wave_instr_pc), 64'h204);
    check("m_req_drop", 64'(hi_fetch_req), 64'd0);
    tick;
    check("m_adv_bytes", 64'(pc_adv_bytes), 64'd8);
    check("m_adv", 64'(pc_adv_valid), 64'd1);

    // Wfid mismatch: request held from LO through CHECK is ignored.
    push_entry(6'd5, 32'h400, 32'h4444_0000, 32'h5555_0000, 1'b1);
    tick;
    wave_ins_half_rqd  = 1'b1;
    wave_ins_half_wfid = 6'd7;
    tick;
    tick;
    wave_ins_half_rqd = 1'b0;
    check("x_no_hi", 64'(wave_instr_valid), 64'd0);
    check("x_adv", 64'(pc_adv_valid), 64'd1);
    check("x_adv_bytes", 64'(pc_adv_bytes), 64'd4);

    // PC wrap on the hi beat.
    push_entry(6'd9, 32'hFFFF_FFFC, 32'h0000_0001, 32'hCAFE_F00D, 1'b1);
    tick;
    check("w_lo_pc", 64'(wave_instr_pc), 64'hFFFF_FFFC);
    tick;
    wave_ins_half_rqd  = 1'b1;
    wave_ins_half_wfid = 6'd9;
    tick;
    wave_ins_half_rqd = 1'b0;
    check("w_hi_instr", 64'(wave_instr), 64'hCAFE_F00D);
    check("w_hi_pc", 64'(wave_instr_pc), 64'h0);
    tick;
    tick;

    // Backpressure: park the FSM in MISS so the FIFO fills, then drain.
    push_entry(6'd1, 32'h500, 32'h5000_0000, 32'h0, 1'b0);
    tick;
    tick;
    wave_ins_half_rqd  = 1'b1;
    wave_ins_half_wfid = 6'd1;
    tick;
    wave_ins_half_rqd = 1'b0;
    check("b_park", 64'(hi_fetch_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_ready%0d", i), 64'(fetch_ready), 64'd1);
      drive_entry(6'(10 + i), 32'h1000 + 32'(i * 16), 32'(i), 32'h0, 1'b0);
      fetch_valid = 1'b1;
      tick;
    end
    check("b_full", 64'(fetch_ready), 64'd0);
    drive_entry(6'd14, 32'h1040, 32'd4, 32'h0, 1'b0);
    tick;
    check("b_still_full", 64'(fetch_ready), 64'd0);
    hi_fetch_ack   = 1'b1;
    hi_fetch_instr = 32'hBEEF_0001;
    tick;
    hi_fetch_ack = 1'b0;
    check("b_hi_instr", 64'(wave_instr), 64'hBEEF_0001);
    check("b_hi_wfid", 64'(wave_wfid), 64'd1);
    idx  = 0;
    pend = 1'b1;
    for (int c = 0; c < 80 && idx < 5; c++) begin
      rdy_before = fetch_ready;
      tick;
      if (pend && rdy_before) begin
        fetch_valid = 1'b0;
        pend        = 1'b0;
      end
      if (wave_instr_valid) begin
        check($sformatf("b_order_wfid%0d", idx), 64'(wave_wfid), 64'(10 + idx));
        check($sformatf("b_order_pc%0d", idx), 64'(wave_instr_pc), 64'(32'h1000 + 32'(idx * 16)));
        idx++;
      end
    end
    fetch_valid = 1'b0;
    check("b_drain_count", 64'(idx), 64'd5);
    tick;
    tick;
    tick;

    // Reset while in MISS drops the entry silently.
    push_entry(6'd2, 32'h600, 32'h6000_0000, 32'h0, 1'b0);
    tick;
    tick;
    wave_ins_half_rqd  = 1'b1;
    wave_ins_half_wfid = 6'd2;
    tick;
    wave_ins_half_rqd = 1'b0;
    check("r_in_miss", 64'(hi_fetch_req), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("r_hreq", 64'(hi_fetch_req), 64'd0);
    check("r_valid", 64'(wave_instr_valid), 64'd0);
    check("r_adv", 64'(pc_adv_valid), 64'd0);
    check("r_ready", 64'(fetch_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("r_quiet_adv%0d", i), 64'(pc_adv_valid), 64'd0);
      check($sformatf("r_quiet_valid%0d", i), 64'(wave_instr_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
